// File: rtl/life_cmd_pkg.sv
// Shared command vocabulary for the life engine and the units that feed it.
// Command codes and default field widths live here so producer and consumer agree.
package life_cmd_pkg;

    localparam int CMD_W = 3;
    localparam int ARG_W = 32;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP         = 3'd0,
        CMD_STEP        = 3'd1,
        CMD_CLEAR       = 3'd2,
        CMD_RANDOM      = 3'd3,
        CMD_TOGGLE_CELL = 3'd4
    } life_cmd_e;

endpackage

// File: rtl/cmd_input_queue_btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, stability counter, and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             settle_s;

    assign settle_s = (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Synchronise, count disagreeing cycles, flip the level once they are long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (settle_s) begin
                    level_r <= sync2_r;
                    press_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/cmd_input_queue.sv
// Turns debounced buttons and an auto-step timer into engine commands, buffered
// in a small show-ahead FIFO and delivered over a valid/ready handshake.
module cmd_input_queue
    import life_cmd_pkg::*;
#(
    parameter int                           N_BUTTONS       = 4,
    parameter int                           DEBOUNCE_CYCLES = 1_000_000,
    parameter int                           FIFO_DEPTH      = 4,
    parameter int                           CMD_W           = life_cmd_pkg::CMD_W,
    parameter int                           ARG_W           = life_cmd_pkg::ARG_W,
    parameter logic [N_BUTTONS*CMD_W-1:0]   BTN_CMD_MAP     = {CMD_STEP, CMD_RANDOM, CMD_CLEAR, CMD_NOP},
    parameter int                           RUN_BTN         = 0,
    parameter int                           STEP_PERIOD     = 10_000_000,
    parameter logic [CMD_W-1:0]             STEP_CMD        = CMD_STEP
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BUTTONS-1:0]          buttons,
    output logic [CMD_W-1:0]              cmd,
    output logic [ARG_W-1:0]              cmd_arg0,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          run_mode,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int TMR_W = $clog2(STEP_PERIOD);
    localparam int BI_W  = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
    localparam logic [N_BUTTONS-1:0] RUN_MASK = N_BUTTONS'(1) << RUN_BTN;

    logic [N_BUTTONS-1:0] press_s;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (buttons[gi]),
            .press (press_s[gi])
        );
    end

    logic                 run_mode_r;
    logic                 overflow_r;
    logic                 auto_pending_r;
    logic [TMR_W-1:0]     timer_r;
    logic [N_BUTTONS-1:0] pending_r;
    logic [ARG_W-1:0]     btn_seq_r;
    logic [ARG_W-1:0]     gen_seq_r;
    logic [CMD_W-1:0]     mem_cmd_r [FIFO_DEPTH];
    logic [ARG_W-1:0]     mem_arg_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]     count_r;
    logic [CMD_W-1:0]     head_cmd_r;
    logic [ARG_W-1:0]     head_arg_r;
    logic                 valid_r;

    logic                 sel_hit_s;
    logic [BI_W-1:0]      sel_btn_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 push_auto_s;
    logic [CMD_W-1:0]     push_cmd_s;
    logic [ARG_W-1:0]     push_arg_s;
    logic [LVL_W-1:0]     count_next_s;
    logic [AW-1:0]        rd_ptr_next_s;
    logic [N_BUTTONS-1:0] clr_s;
    logic [N_BUTTONS-1:0] pending_next_s;
    logic                 drop_s;
    logic                 run_toggle_s;
    logic                 run_stop_s;
    logic                 wrap_s;
    logic [CMD_W-1:0]     head_cmd_next_s;
    logic [ARG_W-1:0]     head_arg_next_s;

    // Priority pick: scanning downwards leaves the lowest pending button selected
    always_comb begin
        sel_hit_s = 1'b0;
        sel_btn_s = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            sel_hit_s = sel_hit_s | pending_r[i];
            sel_btn_s = pending_r[i] ? BI_W'(i) : sel_btn_s;
        end
    end

    assign pop_s         = valid_r & cmd_ready;
    assign push_s        = (sel_hit_s | auto_pending_r) & ((count_r != LVL_W'(FIFO_DEPTH)) | pop_s);
    assign push_auto_s   = push_s & ~sel_hit_s;
    assign push_cmd_s    = sel_hit_s ? BTN_CMD_MAP[int'(sel_btn_s) * CMD_W +: CMD_W] : STEP_CMD;
    assign push_arg_s    = sel_hit_s ? btn_seq_r : gen_seq_r;
    assign count_next_s  = count_r + LVL_W'(push_s) - LVL_W'(pop_s);
    assign rd_ptr_next_s = rd_ptr_r + AW'(pop_s);

    // A press landing on an already pending button is dropped, even if that flag clears now
    assign clr_s          = (push_s & sel_hit_s) ? (N_BUTTONS'(1) << sel_btn_s) : '0;
    assign pending_next_s = (pending_r | press_s) & ~clr_s & ~RUN_MASK;
    assign drop_s         = |(press_s & pending_r & ~RUN_MASK);

    assign run_toggle_s = press_s[RUN_BTN];
    assign run_stop_s   = run_toggle_s & run_mode_r;
    assign wrap_s       = run_mode_r & (timer_r == TMR_W'(STEP_PERIOD - 1));

    // Next head: empty -> idle, bypass when the new entry lands at the read slot, else stored entry
    always_comb begin
        head_cmd_next_s = CMD_W'(CMD_NOP);
        head_arg_next_s = '0;
        if (count_next_s == '0) begin
            head_cmd_next_s = CMD_W'(CMD_NOP);
            head_arg_next_s = '0;
        end else if (count_r == LVL_W'(pop_s)) begin
            head_cmd_next_s = push_cmd_s;
            head_arg_next_s = push_arg_s;
        end else begin
            head_cmd_next_s = mem_cmd_r[rd_ptr_next_s];
            head_arg_next_s = mem_arg_r[rd_ptr_next_s];
        end
    end

    // FIFO storage; pointers and occupancy decide which slots are meaningful
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_cmd_r[wr_ptr_r] <= push_cmd_s;
            mem_arg_r[wr_ptr_r] <= push_arg_s;
        end
    end

    // Control state: pending flags, run mode, timer, sequence counters, FIFO pointers and head
    always_ff @(posedge clk) begin
        if (reset) begin
            run_mode_r     <= 1'b0;
            overflow_r     <= 1'b0;
            auto_pending_r <= 1'b0;
            timer_r        <= '0;
            pending_r      <= '0;
            btn_seq_r      <= '0;
            gen_seq_r      <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            head_cmd_r     <= '0;
            head_arg_r     <= '0;
            valid_r        <= 1'b0;
        end else begin
            pending_r  <= pending_next_s;
            overflow_r <= overflow_r | drop_s;
            run_mode_r <= run_mode_r ^ run_toggle_s;
            if (run_stop_s) begin
                timer_r        <= '0;
                auto_pending_r <= 1'b0;
            end else begin
                timer_r        <= wrap_s ? '0 : (run_mode_r ? timer_r + TMR_W'(1) : timer_r);
                auto_pending_r <= (auto_pending_r & ~push_auto_s) | (wrap_s & ~auto_pending_r);
            end
            btn_seq_r  <= btn_seq_r + ARG_W'(push_s & sel_hit_s);
            gen_seq_r  <= gen_seq_r + ARG_W'(push_auto_s);
            wr_ptr_r   <= wr_ptr_r + AW'(push_s);
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            head_cmd_r <= head_cmd_next_s;
            head_arg_r <= head_arg_next_s;
            valid_r    <= (count_next_s != '0);
        end
    end

    assign cmd        = head_cmd_r;
    assign cmd_arg0   = head_arg_r;
    assign cmd_valid  = valid_r;
    assign run_mode   = run_mode_r;
    assign overflow   = overflow_r;
    assign fifo_level = count_r;

endmodule

// File: tb/tb_cmd_input_queue.sv
// Bench for cmd_input_queue: directed scenarios plus random button/ready traffic,
// compared every cycle against a queue-based reference model.
module tb_cmd_input_queue;

    localparam int N      = 4;
    localparam int DEB    = 4;
    localparam int DEPTH  = 2;
    localparam int PERIOD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  buttons;
    logic [2:0]    cmd;
    logic [31:0]   cmd_arg0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          run_mode;
    logic          overflow;
    logic [1:0]    fifo_level;

    always #5 clk = ~clk;

    cmd_input_queue #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH),
        .BTN_CMD_MAP     (12'b001_011_010_000),
        .RUN_BTN         (0),
        .STEP_PERIOD     (PERIOD),
        .STEP_CMD        (3'd1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .cmd        (cmd),
        .cmd_arg0   (cmd_arg0),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .run_mode   (run_mode),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    typedef struct packed {
        logic [2:0]  c;
        logic [31:0] a;
    } ent_t;

    int          errors = 0;
    int          checks = 0;
    bit [2:0]    btn_code [N] = '{3'd0, 3'd2, 3'd3, 3'd1};
    ent_t        q [$];
    bit          d1 [N];
    bit          d2 [N];
    bit          lvl [N];
    bit          prs [N];
    bit          pend [N];
    int          run_len [N];
    bit          m_run, m_auto, m_ovf;
    int          m_timer;
    logic [31:0] bseq, gseq;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            d1[i] = 0; d2[i] = 0; lvl[i] = 0; prs[i] = 0; pend[i] = 0; run_len[i] = 0;
        end
        m_run = 0; m_auto = 0; m_ovf = 0; m_timer = 0;
        bseq = '0; gseq = '0;
    endtask

    // One clock of the reference behaviour, using the press pulses produced on the previous edge.
    task automatic model_step();
        bit old_pend [N];
        bit old_auto, pop, can, wrap;
        int pick, sz;
        sz       = q.size();
        old_auto = m_auto;
        for (int i = 0; i < N; i++) old_pend[i] = pend[i];
        pop  = (sz > 0) && cmd_ready;
        can  = (sz < DEPTH) || pop;
        if (pop) void'(q.pop_front());
        pick = -1;
        for (int i = 0; i < N; i++) if (pend[i] && pick < 0) pick = i;
        if (can && pick >= 0) begin
            q.push_back({btn_code[pick], bseq});
            bseq++;
            pend[pick] = 0;
        end else if (can && m_auto) begin
            q.push_back({3'd1, gseq});
            gseq++;
            m_auto = 0;
        end
        for (int i = 1; i < N; i++) begin
            if (prs[i] && old_pend[i]) m_ovf = 1;
            else if (prs[i]) pend[i] = 1;
        end
        wrap = m_run && (m_timer == PERIOD - 1);
        if (prs[0] && m_run) begin
            m_run = 0; m_timer = 0; m_auto = 0;
        end else if (prs[0]) begin
            m_run = 1;
        end else if (m_run) begin
            m_timer = wrap ? 0 : m_timer + 1;
            if (wrap && !old_auto) m_auto = 1;
        end
        // Button seen two edges late; level accepted after DEB consecutive disagreeing edges
        for (int i = 0; i < N; i++) begin
            prs[i] = 0;
            if (d2[i] != lvl[i]) run_len[i]++;
            else run_len[i] = 0;
            if (run_len[i] == DEB) begin
                lvl[i] = d2[i];
                prs[i] = d2[i];
                run_len[i] = 0;
            end
            d2[i] = d1[i];
            d1[i] = buttons[i];
        end
    endtask

    task automatic compare_all();
        check_val("valid", cmd_valid, q.size() > 0);
        check_val("level", fifo_level, q.size());
        check_val("run_mode", run_mode, m_run);
        check_val("overflow", overflow, m_ovf);
        if (q.size() > 0) begin
            check_val("cmd", cmd, q[0].c);
            check_val("arg0", cmd_arg0, q[0].a);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        buttons = b;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    int ready_mode;

    initial begin
        reset = 1'b1; buttons = '0; cmd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(3);
        check_val("rst_cmd", cmd, 3'd0);
        check_val("rst_arg0", cmd_arg0, 32'd0);
        check_val("rst_valid", cmd_valid, 1'b0);
        check_val("rst_level", fifo_level, 2'd0);

        // Clean press, then a short glitch that must not register
        cmd_ready = 1'b1;
        hold(4'b0010, 10);
        hold(4'b0000, 20);
        hold(4'b0010, 2);
        hold(4'b0000, 20);

        // Three simultaneous presses against a stalled consumer
        do_reset(2);
        cmd_ready = 1'b0;
        hold(4'b1110, 12);
        check_val("s2_level", fifo_level, 2'd2);
        check_val("s2_cmd", cmd, 3'd2);
        check_val("s2_arg0", cmd_arg0, 32'd0);
        cmd_ready = 1'b1;
        hold(4'b0000, 10);
        check_val("s2_ovf", overflow, 1'b0);

        // Repeated presses into a full FIFO set sticky overflow
        cmd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hold(4'b0010, 8);
            hold(4'b0000, 8);
        end
        check_val("s3_ovf", overflow, 1'b1);
        cmd_ready = 1'b1;
        hold(4'b0000, 20);
        check_val("s3_ovf_sticky", overflow, 1'b1);

        // Auto-run on, free-running steps, then off
        do_reset(2);
        hold(4'b0001, 8);
        hold(4'b0000, 40);
        check_val("s4_run", run_mode, 1'b1);
        hold(4'b0001, 8);
        hold(4'b0000, 30);
        check_val("s4_run_off", run_mode, 1'b0);

        // Auto-run against a stalled consumer: bounded queue, no overflow
        cmd_ready = 1'b0;
        hold(4'b0001, 8);
        hold(4'b0000, 40);
        check_val("s5_level", fifo_level, 2'd2);
        check_val("s5_ovf", overflow, 1'b0);

        // Reset mid-operation flushes everything
        do_reset(1);
        check_val("s6_valid", cmd_valid, 1'b0);
        check_val("s6_level", fifo_level, 2'd0);
        check_val("s6_run", run_mode, 1'b0);
        hold(4'b0100, 10);
        check_val("s6_arg0", cmd_arg0, 32'd0);
        hold(4'b0000, 10);

        // Random traffic with varying consumer behaviour and occasional resets
        ready_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) ready_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) buttons[$urandom_range(0, N - 1)] ^= 1'b1;
            cmd_ready = (ready_mode == 0) ? 1'b0 :
                        (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
